cordic_arbiter: RTL and testbench

Shares the processor's single CORDIC engine among NREQ requesters (processor control unit plus auxiliary masters). Accepts angle requests by valid/ready handshake, grants round-robin, sequences the engine's start/finish protocol, and returns sin/cos to the owning requester as a one-cycle response pulse. Sits between the requesters and the `cordic` instance, whose `angle`/`start`/`sin`/`cos`/`finish` ports it drives and observes exclusively.

---
 rtl/cordic_arb_pkg.sv | 15 +
 rtl/cordic_arb_if.sv | 25 ++
 rtl/cordic_rr_picker.sv | 31 +++
 rtl/cordic_arbiter.sv | 107 ++++++++++
 tb/tb_cordic_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_arb_pkg.sv
// Shared types and default parameters for the CORDIC engine arbiter.
package cordic_arb_pkg;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_W       = 32;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

endpackage

// File: rtl/cordic_arb_if.sv
// Requester-side bus of the CORDIC arbiter: valid/ready requests and one-cycle responses.
interface cordic_arb_if
    import cordic_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_angle;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_sin;
    logic [W-1:0]      rsp_cos;
    logic              rsp_err;

    modport master (
        output req_valid, req_angle,
        input  req_ready, rsp_valid, rsp_sin, rsp_cos, rsp_err
    );

    modport slave (
        input  req_valid, req_angle,
        output req_ready, rsp_valid, rsp_sin, rsp_cos, rsp_err
    );
endinterface

// File: rtl/cordic_rr_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping mod NREQ.
module cordic_rr_picker
    import cordic_arb_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            req_any
);
    logic [IW-1:0] j;

    // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        req_any   = 1'b0;
        j         = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = IW'((int'(rr_ptr) + k) % NREQ);
            if (!req_any && req[j]) begin
                req_any   = 1'b1;
                grant_idx = j;
                grant[j]  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one CORDIC engine among NREQ requesters.
// Optional WAIT-state watchdog enabled by defining CORDIC_ARB_TIMEOUT_EN.
module cordic_arbiter
    import cordic_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int W       = DEF_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst_n,
    cordic_arb_if.slave   bus,
    output logic          busy,
    output logic [W-1:0]  cor_angle,
    output logic          cor_start,
    input  logic [W-1:0]  cor_sin,
    input  logic [W-1:0]  cor_cos,
    input  logic          cor_finish
);
    localparam int IW = $clog2(NREQ);

    arb_state_t      state, state_nxt;
    logic [IW-1:0]   rr_ptr, owner;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic            req_any;
    logic [W-1:0]    sel_angle;
    logic            expired;

    cordic_rr_picker #(.NREQ(NREQ)) u_picker (
        .req       (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .req_any   (req_any)
    );

    always_comb begin
        sel_angle = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_idx == IW'(k)) sel_angle = bus.req_angle[k*W +: W];
        end
    end

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)              wait_cnt <= '0;
        else if (state == ISSUE) wait_cnt <= '0;
        else if (state == WAIT)  wait_cnt <= wait_cnt + 1'b1;
    end

    // The count reaches TIMEOUT on the edge leaving this cycle, so expiry is flagged one count early.
    assign expired = (state == WAIT) && (wait_cnt == CW'(TIMEOUT - 1));
`else
    localparam int timeout_unused = TIMEOUT;
    assign expired = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req_any) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cor_finish || expired) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.req_ready = (state == IDLE) ? grant : '0;
    assign busy          = (state != IDLE);
    assign cor_start     = (state == ISSUE);

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            cor_angle     <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_sin   <= '0;
            bus.rsp_cos   <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            state         <= state_nxt;
            bus.rsp_valid <= '0;
            if (state == IDLE && req_any) begin
                owner     <= grant_idx;
                cor_angle <= sel_angle;
            end
            // A finish on the expiry cycle wins: the engine's result is still good.
            if (state == WAIT && (cor_finish || expired)) begin
                bus.rsp_valid <= NREQ'(1) << owner;
                bus.rsp_sin   <= cor_finish ? cor_sin : '0;
                bus.rsp_cos   <= cor_finish ? cor_cos : '0;
                bus.rsp_err   <= !cor_finish;
            end
            if (state == RESP) begin
                rr_ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter with a behavioural engine model (sin=~a, cos=halfword swap).
module tb_cordic_arbiter;
    import cordic_arb_pkg::*;

    localparam int NREQ    = 4;
    localparam int W       = 32;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cordic_arb_if #(.NREQ(NREQ), .W(W)) bus ();

    logic         busy, cor_start, cor_finish;
    logic [W-1:0] cor_angle;
    logic [W-1:0] cor_sin = 32'hDEAD_BEEF;
    logic [W-1:0] cor_cos = 32'hFEED_FACE;

    cordic_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .busy       (busy),
        .cor_angle  (cor_angle),
        .cor_start  (cor_start),
        .cor_sin    (cor_sin),
        .cor_cos    (cor_cos),
        .cor_finish (cor_finish)
    );

    typedef struct {
        logic [NREQ-1:0] who;
        logic [W-1:0]    s;
        logic [W-1:0]    c;
        logic            err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    int   rsp_cnt = 0;
    int   rsp_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic timeout_fail(input string name);
        n_total++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    function automatic logic [W-1:0] f_sin(input logic [W-1:0] a);
        return ~a;
    endfunction

    function automatic logic [W-1:0] f_cos(input logic [W-1:0] a);
        return {a[15:0], a[31:16]};
    endfunction

    // Engine model: finishes eng_lat cycles after the start cycle unless hung.
    int           eng_lat  = 20;
    bit           eng_hang = 1'b0;
    bit           eng_busy = 1'b0;
    int           eng_cnt  = 0;
    logic         eng_fin  = 1'b0;
    logic         spur_fin = 1'b0;
    logic [W-1:0] eng_a    = '0;
    assign cor_finish = eng_fin | spur_fin;

    initial forever begin
        @(posedge clk);
        #2;
        eng_fin = 1'b0;
        if (!rst_n) begin
            eng_busy = 1'b0;
        end else if (cor_start) begin
            eng_busy = 1'b1;
            eng_cnt  = eng_lat;
            eng_a    = cor_angle;
        end else if (eng_busy && !eng_hang) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                eng_fin  = 1'b1;
                cor_sin  = f_sin(eng_a);
                cor_cos  = f_cos(eng_a);
                eng_busy = 1'b0;
            end
        end
    end

    // Monitor: every response pulse is matched against the oldest expectation.
    initial forever begin
        @(negedge clk);
        if (rst_n && bus.rsp_valid !== '0) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_owner", 64'(bus.rsp_valid), 64'(e.who));
                check("rsp_sin",   64'(bus.rsp_sin),   64'(e.s));
                check("rsp_cos",   64'(bus.rsp_cos),   64'(e.c));
                check("rsp_err",   64'(bus.rsp_err),   64'(e.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push_ok(input int idx, input logic [W-1:0] a);
        sb.push_back('{NREQ'(1) << idx, f_sin(a), f_cos(a), 1'b0});
    endtask

    task automatic set_angle(input int idx, input logic [W-1:0] a);
        bus.req_angle[idx*W +: W] = a;
    endtask

    task automatic wait_grant(output logic [NREQ-1:0] g);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.req_ready == '0 && n < 200);
        if (bus.req_ready == '0) timeout_fail("grant_wait");
        g = bus.req_ready;
    endtask

    task automatic wait_rsp(input int prev);
        int n = 0;
        while (rsp_cnt == prev && n < 200) begin
            tick();
            n++;
        end
        if (rsp_cnt == prev) timeout_fail("rsp_wait");
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        if (sb.size() != 0) timeout_fail("drain");
    endtask

    logic [NREQ-1:0] g;
    int              t_acc, prev, viol, n, s_cyc;

    initial begin
        bus.req_valid = '0;
        bus.req_angle = '0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 0);
        check("rst_busy",      64'(busy),          0);
        check("rst_cor_start", 64'(cor_start),     0);
        check("rst_cor_angle", 64'(cor_angle),     0);
        check("rst_rsp_sin",   64'(bus.rsp_sin),   0);
        check("rst_rsp_err",   64'(bus.rsp_err),   0);
        tick();
        rst_n = 1'b1;

        // Single request from requester 2, engine latency 20.
        eng_lat = 20;
        prev    = rsp_cnt;
        set_angle(2, 32'h3243F6A9);
        bus.req_valid = 4'b0100;
        sb.push_back('{4'b0100, 32'hCDBC0956, 32'hF6A93243, 1'b0});
        @(negedge clk);
        t_acc = cyc;
        check("t1_ready", 64'(bus.req_ready), 64'(4'b0100));
        tick();
        @(negedge clk);
        check("t1_start",       64'(cor_start),     1);
        check("t1_busy",        64'(busy),          1);
        check("t1_ready_issue", 64'(bus.req_ready), 0);
        check("t1_angle",       64'(cor_angle),     64'h3243F6A9);
        tick();
        bus.req_valid = '0;
        wait_rsp(prev);
        check("t1_latency", 64'(rsp_cyc - t_acc), 22);

        // All four requesting continuously from reset: grant order 0,1,2,3,0.
        do_reset();
        eng_lat = 3;
        for (int i = 0; i < NREQ; i++) set_angle(i, 32'h1111_1111 * (i + 1));
        bus.req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g);
            check($sformatf("t2_grant%0d", k), 64'(g), 64'(NREQ'(1) << (k % NREQ)));
            push_ok(k % NREQ, 32'h1111_1111 * ((k % NREQ) + 1));
            tick();
        end
        bus.req_valid = '0;
        drain();

        // Requester 1 arrives while 3 is being served.
        do_reset();
        eng_lat = 10;
        set_angle(3, 32'hA5A5_0003);
        set_angle(1, 32'h0BAD_0001);
        bus.req_valid = 4'b1000;
        wait_grant(g);
        check("t3_grant3", 64'(g), 64'(4'b1000));
        push_ok(3, 32'hA5A5_0003);
        tick();
        bus.req_valid = 4'b0010;
        viol = 0;
        n    = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy && bus.req_ready != '0) viol++;
            if (busy && cor_angle != 32'hA5A5_0003) viol++;
        end while (busy && n < 100);
        check("t3_busy_violations", 64'(viol), 0);
        check("t3_grant1",          64'(bus.req_ready), 64'(4'b0010));
        check("t3_accept_gap",      64'(cyc - rsp_cyc), 1);
        push_ok(1, 32'h0BAD_0001);
        tick();
        bus.req_valid = '0;
        drain();

        // Reset during WAIT abandons the transaction and rewinds rr_ptr.
        do_reset();
        eng_lat = 30;
        set_angle(2, 32'h2222_AAAA);
        bus.req_valid = 4'b0100;
        wait_grant(g);
        push_ok(2, 32'h2222_AAAA);
        tick();
        bus.req_valid = '0;
        drain();
        set_angle(1, 32'h7777_1111);
        bus.req_valid = 4'b0010;
        wait_grant(g);
        check("t4_grant1", 64'(g), 64'(4'b0010));
        push_ok(1, 32'h7777_1111);
        tick();
        bus.req_valid = '0;
        repeat (5) tick();
        prev  = rsp_cnt;
        rst_n = 1'b0;
        sb.delete();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t4_busy",      64'(busy),          0);
        check("t4_rsp_valid", 64'(bus.rsp_valid), 0);
        check("t4_cor_angle", 64'(cor_angle),     0);
        check("t4_cor_start", 64'(cor_start),     0);
        check("t4_rsp_sin",   64'(bus.rsp_sin),   0);
        check("t4_rsp_cos",   64'(bus.rsp_cos),   0);
        repeat (40) tick();
        check("t4_no_rsp", 64'(rsp_cnt), 64'(prev));
        set_angle(0, 32'h0000_5A5A);
        set_angle(3, 32'h3333_5A5A);
        bus.req_valid = 4'b1001;
        wait_grant(g);
        check("t4_ptr_rewound", 64'(g), 64'(4'b0001));
        push_ok(0, 32'h0000_5A5A);
        tick();
        bus.req_valid = '0;
        drain();

        // Spurious finish while idle.
        prev     = rsp_cnt;
        spur_fin = 1'b1;
        tick();
        spur_fin = 1'b0;
        @(negedge clk);
        check("t5_idle_busy", 64'(busy), 0);
        repeat (5) tick();
        check("t5_no_rsp", 64'(rsp_cnt), 64'(prev));

`ifdef CORDIC_ARB_TIMEOUT_EN
        // Hung engine: error response 65 cycles after start.
        do_reset();
        eng_hang = 1'b1;
        prev     = rsp_cnt;
        set_angle(0, 32'h1234_5678);
        bus.req_valid = 4'b0001;
        wait_grant(g);
        sb.push_back('{4'b0001, '0, '0, 1'b1});
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        s_cyc = cyc;
        wait_rsp(prev);
        check("t6_timeout_latency", 64'(rsp_cyc - s_cyc), 65);

        // Finish on the expiry cycle yields a normal result.
        eng_hang = 1'b0;
        eng_lat  = TIMEOUT;
        prev     = rsp_cnt;
        set_angle(1, 32'h4321_8765);
        bus.req_valid = 4'b0010;
        wait_grant(g);
        push_ok(1, 32'h4321_8765);
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        s_cyc = cyc;
        wait_rsp(prev);
        check("t6_expiry_finish_latency", 64'(rsp_cyc - s_cyc), 65);
`endif

        repeat (3) tick();
        check("sb_empty", 64'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
